prim_flop_nsync_filter: RTL and testbench

//  Multi-bit N-stage input synchronizer with optional per-bit glitch filter and edge-pulse outputs.

---
 rtl/prim_flop_nsync_filter.sv | 63 ++++++
 tb/tb_prim_flop_nsync_filter.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/prim_flop_nsync_filter.sv
// prim_flop_nsync_filter: N-stage multi-bit synchronizer with optional per-bit glitch filter and edge pulses
//   clk_i, rst_ni  : clock, asynchronous active-low reset
//   d_i            : asynchronous level inputs, one independent channel per bit
//   en_i           : filter update enable
//   sync_o         : raw synchronized value (last chain stage)
//   q_o            : filtered stable value
//   rise_o, fall_o : one-cycle pulses on q_o 0->1 / 1->0
module prim_flop_nsync_filter #(
  parameter int unsigned      Width        = 16,
  parameter int unsigned      Stages       = 2,
  parameter logic [Width-1:0] ResetValue   = '0,
  parameter logic             FilterEn     = 1'b1,
  parameter int unsigned      FilterCycles = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [Width-1:0] d_i,
  input  logic             en_i,
  output logic [Width-1:0] sync_o,
  output logic [Width-1:0] q_o,
  output logic [Width-1:0] rise_o,
  output logic [Width-1:0] fall_o
);
  // chain_q[0] captures d_i; the oldest stage drives sync_o
  logic [Stages-1:0][Width-1:0] chain_q;
  logic [Width-1:0] q_prev_q;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) chain_q <= {Stages{ResetValue}};
    else chain_q <= {chain_q[Stages-2:0], d_i};
  assign sync_o = chain_q[Stages-1];
  if (FilterEn) begin : g_filt
    localparam int unsigned CntW = $clog2(FilterCycles + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(FilterCycles - 1);
    logic [Width-1:0][CntW-1:0] cnt_q, cnt_d;
    logic [Width-1:0] q_q, q_d;
    // a run of differing cycles is counted; the last one of a full window commits sync_o
    always_comb begin
      cnt_d = cnt_q;
      q_d = q_q;
      for (int i = 0; i < Width; i++) begin
        cnt_d[i] = (!en_i || sync_o[i] == q_q[i] || cnt_q[i] == CntMax) ? '0 : cnt_q[i] + CntW'(1);
        q_d[i] = (en_i && sync_o[i] != q_q[i] && cnt_q[i] == CntMax) ? sync_o[i] : q_q[i];
      end
    end
    always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) begin
        cnt_q <= '0;
        q_q <= ResetValue;
      end else begin
        cnt_q <= cnt_d;
        q_q <= q_d;
      end
    assign q_o = q_q;
  end else begin : g_bypass
    assign q_o = sync_o;
  end
  // history starts at ResetValue so release from reset never yields a pulse
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) q_prev_q <= ResetValue;
    else q_prev_q <= q_o;
  assign rise_o = q_o & ~q_prev_q;
  assign fall_o = ~q_o & q_prev_q;
endmodule

// File: tb/tb_prim_flop_nsync_filter.sv
// tb_prim_flop_nsync_filter: scoreboard bench for the filtered synchronizer and its bypass variant
module tb_prim_flop_nsync_filter;
  typedef struct {
    int          at;
    logic        b;
    string       nm;
    logic [31:0] v;
  } exp_t;
  logic clk, rst_n, en;
  logic [7:0] d, d_b;
  logic [7:0] sync_a, q_a, rise_a, fall_a;
  logic [7:0] sync_b, q_b, rise_b, fall_b;
  int total = 0;
  int bad = 0;
  exp_t sb[$];
  prim_flop_nsync_filter #(
    .Width(8), .Stages(2), .ResetValue(8'h00), .FilterEn(1'b1), .FilterCycles(4)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .d_i(d), .en_i(en),
    .sync_o(sync_a), .q_o(q_a), .rise_o(rise_a), .fall_o(fall_a)
  );
  prim_flop_nsync_filter #(
    .Width(8), .Stages(3), .ResetValue(8'hFF), .FilterEn(1'b0), .FilterCycles(4)
  ) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .d_i(d_b), .en_i(en),
    .sync_o(sync_b), .q_o(q_b), .rise_o(rise_b), .fall_o(fall_b)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  function automatic logic [31:0] pk(logic [7:0] s, logic [7:0] q, logic [7:0] r, logic [7:0] f);
    return {s, q, r, f};
  endfunction
  task automatic test_reset();
    exp_t e;
    logic [31:0] act;
    for (int k = 0; k < 10; k++) begin
      rst_n = (k >= 2);
      d = 8'hFF;
      en = 1'b1;
      sb.push_back('{k, 1'b0, "reset_a", pk(k >= 3 ? 8'hFF : 8'h00, k >= 7 ? 8'hFF : 8'h00, k == 7 ? 8'hFF : 8'h00, 8'h00)});
      if (k < 2) sb.push_back('{k, 1'b1, "reset_b", pk(8'hFF, 8'hFF, 8'h00, 8'h00)});
      @(posedge clk); #1;
      while (sb.size() > 0 && sb[0].at == k) begin
        e = sb.pop_front();
        act = e.b ? {sync_b, q_b, rise_b, fall_b} : {sync_a, q_a, rise_a, fall_a};
        total++;
        if (act !== e.v) begin
          bad++;
          $display("FAIL %s k=%0d got=%h want=%h", e.nm, k, act, e.v);
        end
      end
    end
  endtask
  task automatic test_glitch();
    exp_t e;
    logic [31:0] act;
    for (int k = 0; k < 21; k++) begin
      d = (k >= 10 && k <= 12) ? 8'h08 : 8'h00;
      en = 1'b1;
      sb.push_back('{k, 1'b0, "glitch", pk(k == 0 ? 8'hFF : (k >= 11 && k <= 13) ? 8'h08 : 8'h00,
                                           k < 5 ? 8'hFF : 8'h00, 8'h00, k == 5 ? 8'hFF : 8'h00)});
      @(posedge clk); #1;
      while (sb.size() > 0 && sb[0].at == k) begin
        e = sb.pop_front();
        act = e.b ? {sync_b, q_b, rise_b, fall_b} : {sync_a, q_a, rise_a, fall_a};
        total++;
        if (act !== e.v) begin
          bad++;
          $display("FAIL %s k=%0d got=%h want=%h", e.nm, k, act, e.v);
        end
      end
    end
  endtask
  task automatic test_pulse();
    exp_t e;
    logic [31:0] act;
    for (int k = 0; k < 13; k++) begin
      d = k <= 3 ? 8'h08 : 8'h00;
      en = 1'b1;
      sb.push_back('{k, 1'b0, "pulse", pk((k >= 1 && k <= 4) ? 8'h08 : 8'h00, (k >= 5 && k <= 8) ? 8'h08 : 8'h00,
                                          k == 5 ? 8'h08 : 8'h00, k == 9 ? 8'h08 : 8'h00)});
      @(posedge clk); #1;
      while (sb.size() > 0 && sb[0].at == k) begin
        e = sb.pop_front();
        act = e.b ? {sync_b, q_b, rise_b, fall_b} : {sync_a, q_a, rise_a, fall_a};
        total++;
        if (act !== e.v) begin
          bad++;
          $display("FAIL %s k=%0d got=%h want=%h", e.nm, k, act, e.v);
        end
      end
    end
  endtask
  task automatic test_enable();
    exp_t e;
    logic [31:0] act;
    for (int k = 0; k < 30; k++) begin
      d = k < 18 ? 8'h5A : 8'h00;
      en = (k >= 12 && k < 22) || k >= 24;
      sb.push_back('{k, 1'b0, "enable", pk((k >= 1 && k <= 18) ? 8'h5A : 8'h00, (k >= 15 && k <= 26) ? 8'h5A : 8'h00,
                                           k == 15 ? 8'h5A : 8'h00, k == 27 ? 8'h5A : 8'h00)});
      @(posedge clk); #1;
      while (sb.size() > 0 && sb[0].at == k) begin
        e = sb.pop_front();
        act = e.b ? {sync_b, q_b, rise_b, fall_b} : {sync_a, q_a, rise_a, fall_a};
        total++;
        if (act !== e.v) begin
          bad++;
          $display("FAIL %s k=%0d got=%h want=%h", e.nm, k, act, e.v);
        end
      end
    end
  endtask
  task automatic test_rst_mid();
    exp_t e;
    logic [31:0] act;
    for (int k = 0; k < 14; k++) begin
      d = 8'h01;
      en = 1'b1;
      rst_n = !(k == 4 || k == 5);
      sb.push_back('{k, 1'b0, "rst_mid", pk(((k >= 1 && k <= 3) || k >= 7) ? 8'h01 : 8'h00, k >= 11 ? 8'h01 : 8'h00,
                                            k == 11 ? 8'h01 : 8'h00, 8'h00)});
      @(posedge clk); #1;
      while (sb.size() > 0 && sb[0].at == k) begin
        e = sb.pop_front();
        act = e.b ? {sync_b, q_b, rise_b, fall_b} : {sync_a, q_a, rise_a, fall_a};
        total++;
        if (act !== e.v) begin
          bad++;
          $display("FAIL %s k=%0d got=%h want=%h", e.nm, k, act, e.v);
        end
      end
    end
  endtask
  task automatic test_bypass();
    exp_t e;
    logic [31:0] act;
    for (int k = 0; k < 8; k++) begin
      d_b = 8'h7F;
      en = k[0];
      sb.push_back('{k, 1'b1, "bypass", pk(k >= 2 ? 8'h7F : 8'hFF, k >= 2 ? 8'h7F : 8'hFF, 8'h00, k == 2 ? 8'h80 : 8'h00)});
      @(posedge clk); #1;
      while (sb.size() > 0 && sb[0].at == k) begin
        e = sb.pop_front();
        act = e.b ? {sync_b, q_b, rise_b, fall_b} : {sync_a, q_a, rise_a, fall_a};
        total++;
        if (act !== e.v) begin
          bad++;
          $display("FAIL %s k=%0d got=%h want=%h", e.nm, k, act, e.v);
        end
      end
    end
  endtask
  initial begin
    rst_n = 1'b0;
    en = 1'b1;
    d = 8'hFF;
    d_b = 8'hFF;
    test_reset();
    test_glitch();
    test_pulse();
    test_enable();
    test_rst_mid();
    test_bypass();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
